ib_tag_sequencer_mc: RTL
========================

IB_TAG_SEQUENCER_MC -- requirements
Module: ib_tag_sequencer_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of user request channels (1..8).
REQ-002 SHALL have parameter USR_TAG_WIDTH, default 8, width of user tag per channel.
REQ-003 SHALL have parameter EP_TAG_WIDTH, default 5, endpoint tag width; tag pool NUM_TAGS = 2**EP_TAG_WIDTH; CH_WIDTH = max(1, clog2(NUM_CH)).
REQ-004 SHALL have port CLK  in  1  sole clock; all state rising-edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port USR_REQ  in  NUM_CH  per-channel tag request.
REQ-007 SHALL have port USR_TAG  in  NUM_CH*USR_TAG_WIDTH  per-channel user tag; channel i at bits [i*USR_TAG_WIDTH +: USR_TAG_WIDTH].
REQ-008 SHALL have port USR_ACK  out  NUM_CH  one-hot grant; request consumed this cycle.
REQ-009 SHALL have port EP_TAG  out  EP_TAG_WIDTH  endpoint tag allocated to granted request.
REQ-010 SHALL have port EP_TAG_VLD  out  1  high whenever any USR_ACK bit is high.
REQ-011 SHALL have port EP_CPL_VLD  in  1  completion present.
REQ-012 SHALL have port EP_CPL_TAG  in  EP_TAG_WIDTH  completion endpoint tag.
REQ-013 SHALL have port EP_CPL_LAST  in  1  last completion for the tag; frees it.
REQ-014 SHALL have port USR_CPL_VLD  out  1  translated completion valid.
REQ-015 SHALL have port USR_CPL_TAG  out  USR_TAG_WIDTH  original user tag.
REQ-016 SHALL have port USR_CPL_CH  out  CH_WIDTH  originating channel index.
REQ-017 SHALL have port USR_CPL_LAST  out  1  registered copy of EP_CPL_LAST.
REQ-018 SHALL have port FULL  out  1  no free endpoint tag.
REQ-019 SHALL have port CPL_ERR  out  1  one-cycle pulse: completion to unallocated tag.

Function
REQ-020 SHALL keep a NUM_TAGS-bit allocation bitmap and a NUM_TAGS-entry table of {user tag, channel}.
REQ-021 SHALL grant combinationally in the request cycle: at most one channel, chosen round-robin starting at the channel after the last granted one; only when FULL=0.
REQ-022 SHALL allocate the lowest-index free tag; EP_TAG valid same cycle as USR_ACK; bitmap bit and table entry written on that clock edge.
REQ-023 SHALL advance the round-robin pointer only on a grant; with NUM_CH=1 the pointer is constant 0.
REQ-024 SHALL translate a completion with 1-cycle latency: USR_CPL_VLD/TAG/CH/LAST registered from table lookup of EP_CPL_TAG.
REQ-025 SHALL clear the bitmap bit at the edge ending a valid completion with EP_CPL_LAST=1; with EP_CPL_LAST=0 the tag stays allocated.
REQ-026 SHALL, for completion to a tag whose bitmap bit is 0, suppress USR_CPL_VLD and pulse CPL_ERR the following cycle; bitmap unchanged.
REQ-027 SHALL not reallocate a tag in the same cycle it is freed; freed tag becomes allocatable next cycle.
REQ-028 SHALL accept allocation and completion in the same cycle independently.
REQ-029 SHALL drive FULL combinationally from the registered bitmap (all bits set).

Reset
REQ-030 SHALL on RESET=0 asynchronously clear bitmap, round-robin pointer to 0, USR_CPL_VLD, USR_CPL_LAST, CPL_ERR to 0; table contents need not be cleared.
REQ-031 SHALL drive USR_ACK=0, EP_TAG_VLD=0, FULL=0 while RESET=0; in-flight tags are dropped, completions after reset are reported as CPL_ERR.

Configuration
REQ-032 SHALL, with IB_TAG_SEQ_INFLIGHT_CNT_EN defined, add output INFLIGHT (EP_TAG_WIDTH+1 bits), registered count of allocated tags, reset 0, +1 per grant, -1 per freeing completion, unchanged when both coincide; without it the port and counter SHALL not exist.

Verification
REQ-033 SHALL test: reset, USR_REQ=0001, USR_TAG ch0=0x3C -> USR_ACK=0001, EP_TAG=0, EP_TAG_VLD=1; completion tag 0 LAST=1 -> next cycle USR_CPL_VLD=1, USR_CPL_TAG=0x3C, USR_CPL_CH=0.
REQ-034 SHALL test: USR_REQ=1111 held 4 cycles -> grants ch0,1,2,3 in order, EP_TAG 0,1,2,3.
REQ-035 SHALL test: 32 grants -> FULL=1, USR_ACK=0 on further requests; one LAST completion of tag 7 with concurrent request -> no grant that cycle, grant of EP_TAG 7 next cycle.
REQ-036 SHALL test: tag 2 completion with LAST=0 twice, then LAST=1 -> three USR_CPL_VLD pulses, tag 2 free only after third.
REQ-037 SHALL test: completion to unallocated tag 9 -> CPL_ERR=1 for one cycle, USR_CPL_VLD=0.
REQ-038 SHALL test: RESET asserted with 5 tags in flight -> outputs reset immediately; subsequent allocation starts at EP_TAG 0; INFLIGHT=0 when macro defined.

Source files
------------

// File: rtl/ib_tag_sequencer_mc.sv
// ib_tag_sequencer_mc: multi-channel endpoint tag allocator and completion translator
//   CLK, RESET (async, active-low)
//   USR_REQ, USR_TAG -> USR_ACK, EP_TAG, EP_TAG_VLD : round-robin grant, lowest free tag allocated
//   EP_CPL_VLD, EP_CPL_TAG, EP_CPL_LAST -> USR_CPL_VLD, USR_CPL_TAG, USR_CPL_CH, USR_CPL_LAST : 1-cycle translation
//   FULL : every endpoint tag allocated; CPL_ERR : pulse for a completion to an unallocated tag
//   INFLIGHT : allocated-tag count, present only with IB_TAG_SEQ_INFLIGHT_CNT_EN defined
module ib_tag_sequencer_mc #(
  parameter int NUM_CH = 4,
  parameter int USR_TAG_WIDTH = 8,
  parameter int EP_TAG_WIDTH = 5,
  localparam int NUM_TAGS = 2**EP_TAG_WIDTH,
  localparam int CH_WIDTH = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [NUM_CH-1:0]                 USR_REQ,
  input  logic [NUM_CH*USR_TAG_WIDTH-1:0]   USR_TAG,
  output logic [NUM_CH-1:0]                 USR_ACK,
  output logic [EP_TAG_WIDTH-1:0]           EP_TAG,
  output logic                              EP_TAG_VLD,
  input  logic                              EP_CPL_VLD,
  input  logic [EP_TAG_WIDTH-1:0]           EP_CPL_TAG,
  input  logic                              EP_CPL_LAST,
  output logic                              USR_CPL_VLD,
  output logic [USR_TAG_WIDTH-1:0]          USR_CPL_TAG,
  output logic [CH_WIDTH-1:0]               USR_CPL_CH,
  output logic                              USR_CPL_LAST,
  output logic                              FULL,
`ifdef IB_TAG_SEQ_INFLIGHT_CNT_EN
  output logic [EP_TAG_WIDTH:0]             INFLIGHT,
`endif
  output logic                              CPL_ERR
);
  logic [NUM_TAGS-1:0] alloc;
  logic [CH_WIDTH-1:0] ptr, sel, idx;
  logic [EP_TAG_WIDTH-1:0] free_tag;
  logic [USR_TAG_WIDTH-1:0] usr_tag_sel;
  logic [USR_TAG_WIDTH-1:0] tag_tbl [NUM_TAGS];
  logic [CH_WIDTH-1:0] ch_tbl [NUM_TAGS];
  logic hit_req, grant, cpl_hit, cpl_free;
  // descending scan: the last match written is the one closest to ptr
  always_comb begin
    sel = ptr;
    hit_req = 1'b0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_WIDTH'((int'(ptr) + i) % NUM_CH);
      if (USR_REQ[idx]) begin
        sel = idx;
        hit_req = 1'b1;
      end
    end
  end
  always_comb begin
    free_tag = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--)
      if (!alloc[EP_TAG_WIDTH'(t)]) free_tag = EP_TAG_WIDTH'(t);
  end
  // FULL and the grant come from the registered bitmap, so a tag freed this cycle waits a cycle
  assign FULL = &alloc;
  assign grant = RESET & hit_req & ~FULL;
  assign USR_ACK = grant ? NUM_CH'(1) << sel : '0;
  assign EP_TAG = free_tag;
  assign EP_TAG_VLD = grant;
  assign usr_tag_sel = USR_TAG[int'(sel)*USR_TAG_WIDTH +: USR_TAG_WIDTH];
  assign cpl_hit = EP_CPL_VLD & alloc[EP_CPL_TAG];
  assign cpl_free = cpl_hit & EP_CPL_LAST;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      alloc <= '0;
      ptr <= '0;
      USR_CPL_VLD <= 1'b0;
      USR_CPL_LAST <= 1'b0;
      CPL_ERR <= 1'b0;
    end else begin
      alloc <= (alloc & ~(NUM_TAGS'(cpl_free) << EP_CPL_TAG)) | (NUM_TAGS'(grant) << free_tag);
      ptr <= grant ? CH_WIDTH'((int'(sel) + 1) % NUM_CH) : ptr;
      USR_CPL_VLD <= cpl_hit;
      USR_CPL_LAST <= EP_CPL_LAST;
      CPL_ERR <= EP_CPL_VLD & ~alloc[EP_CPL_TAG];
    end
  end
  always_ff @(posedge CLK) begin
    if (grant) begin
      tag_tbl[free_tag] <= usr_tag_sel;
      ch_tbl[free_tag] <= sel;
    end
    USR_CPL_TAG <= tag_tbl[EP_CPL_TAG];
    USR_CPL_CH <= ch_tbl[EP_CPL_TAG];
  end
`ifdef IB_TAG_SEQ_INFLIGHT_CNT_EN
  localparam int IW = EP_TAG_WIDTH + 1;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) INFLIGHT <= '0;
    else INFLIGHT <= INFLIGHT + IW'(grant) - IW'(cpl_free);
  end
`else
`endif
endmodule
